// File: rtl/color_col_tracker.sv
// color_col_tracker: streams a frame buffer in raster order, filters each pixel against a
// selectable target colour, writes the filtered image out, and tracks the ROI column with
// the most hits. The peak is reported once per frame with a one-cycle strobe.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              run frames while high (sampled in IDLE and REPORT only)
//   mode                target colour: 00 red, 01 green, 10 blue, 11 bypass
//   thr_hi, thr_lo      target channel >= thr_hi, other channels < thr_lo
//   orig_pxl            original buffer read data, one cycle after orig_addr
//   orig_addr           original buffer read address
//   proc_we/addr/pxl    processed buffer write port
//   frame_start         pulse on the first SCAN cycle of a frame
//   peak_col, peak_cnt  last reported peak column and its hit count
//   result_valid        one-cycle pulse when peak_col/peak_cnt update
module color_col_tracker #(
  parameter int unsigned C_IMG_COLS = 80,
  parameter int unsigned C_IMG_ROWS = 60,
  parameter int unsigned C_NB_ADDR  = 13,
  parameter int unsigned C_NB_COL   = 7,
  parameter int unsigned C_NB_ROW   = 6,
  parameter int unsigned C_NB_CH    = 4,
  parameter int unsigned C_NB_CNT   = 6,
  parameter int unsigned C_ROI_C0   = 8,
  parameter int unsigned C_ROI_C1   = 71,
  parameter int unsigned C_ROI_R0   = 6,
  parameter int unsigned C_ROI_R1   = 53
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [C_NB_CH-1:0]     thr_hi,
  input  logic [C_NB_CH-1:0]     thr_lo,
  input  logic [3*C_NB_CH-1:0]   orig_pxl,
  output logic [C_NB_ADDR-1:0]   orig_addr,
  output logic                   proc_we,
  output logic [C_NB_ADDR-1:0]   proc_addr,
  output logic [3*C_NB_CH-1:0]   proc_pxl,
  output logic                   frame_start,
  output logic [C_NB_COL-1:0]    peak_col,
  output logic [C_NB_CNT-1:0]    peak_cnt,
  output logic                   result_valid
);

  localparam logic [C_NB_ADDR-1:0] PixLast = C_NB_ADDR'(C_IMG_COLS * C_IMG_ROWS - 1);
  localparam logic [C_NB_COL-1:0]  ColLast = C_NB_COL'(C_IMG_COLS - 1);
  localparam logic [C_NB_ROW-1:0]  RowLast = C_NB_ROW'(C_IMG_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StReport} state_e;

  state_e                state_q, state_d;
  logic [C_NB_ADDR-1:0]  pix_q, pix_d;
  logic [C_NB_COL-1:0]   col_q, col_d;
  logic [C_NB_ROW-1:0]   row_q, row_d;

  // Read-latency alignment stage: matches address/position to orig_pxl.
  logic                  valid_dly_q;
  logic [C_NB_ADDR-1:0]  addr_dly_q;
  logic [C_NB_COL-1:0]   col_dly_q;
  logic                  roi_dly_q;
  logic                  roi_now;

  logic [C_NB_CNT-1:0]   bin_q [C_IMG_COLS];
  logic [C_NB_CNT-1:0]   bin_cur, bin_inc;
  logic [C_NB_CNT-1:0]   pk_cnt_q;
  logic [C_NB_COL-1:0]   pk_col_q;
  logic [C_NB_CNT-1:0]   peak_cnt_q;
  logic [C_NB_COL-1:0]   peak_col_q;
  logic                  result_valid_q;

  logic [C_NB_CH-1:0]    ch_r, ch_g, ch_b;
  logic                  hit, upd;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StScan;
      end
      StScan: begin
        if (pix_q == PixLast) begin
          state_d = StDrain;
          pix_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          pix_d = pix_q + 1'b1;
          if (col_q == ColLast) begin
            col_d = '0;
            row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain:  state_d = StReport;
      StReport: state_d = enable ? StScan : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign roi_now = (col_q >= C_NB_COL'(C_ROI_C0)) && (col_q <= C_NB_COL'(C_ROI_C1)) &&
                   (row_q >= C_NB_ROW'(C_ROI_R0)) && (row_q <= C_NB_ROW'(C_ROI_R1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pix_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      valid_dly_q <= 1'b0;
      addr_dly_q  <= '0;
      col_dly_q   <= '0;
      roi_dly_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      col_q       <= col_d;
      row_q       <= row_d;
      valid_dly_q <= (state_q == StScan);
      addr_dly_q  <= pix_q;
      col_dly_q   <= col_q;
      roi_dly_q   <= roi_now;
    end
  end

  // Pixel classification
  assign ch_r = orig_pxl[3*C_NB_CH-1 -: C_NB_CH];
  assign ch_g = orig_pxl[2*C_NB_CH-1 -: C_NB_CH];
  assign ch_b = orig_pxl[C_NB_CH-1:0];

  always_comb begin
    hit = 1'b0;
    case (mode)
      2'b00:   hit = (ch_r >= thr_hi) && (ch_g < thr_lo) && (ch_b < thr_lo);
      2'b01:   hit = (ch_g >= thr_hi) && (ch_r < thr_lo) && (ch_b < thr_lo);
      2'b10:   hit = (ch_b >= thr_hi) && (ch_r < thr_lo) && (ch_g < thr_lo);
      default: hit = 1'b0;
    endcase
  end

  // Gated by the write strobe so the data bus stays quiet outside writes.
  assign proc_pxl  = (valid_dly_q && ((mode == 2'b11) || hit)) ? orig_pxl : '0;
  assign proc_we   = valid_dly_q;
  assign proc_addr = addr_dly_q;
  assign orig_addr = pix_q;
  assign frame_start = (state_q == StScan) && (pix_q == '0);

  // Histogram and running peak
  assign upd     = valid_dly_q && hit && roi_dly_q;
  assign bin_cur = bin_q[col_dly_q];
  assign bin_inc = (&bin_cur) ? bin_cur : bin_cur + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(C_IMG_COLS); i++) bin_q[i] <= '0;
      pk_cnt_q <= '0;
      pk_col_q <= '0;
    end else if (state_q == StReport) begin
      for (int i = 0; i < int'(C_IMG_COLS); i++) bin_q[i] <= '0;
      pk_cnt_q <= '0;
      pk_col_q <= '0;
    end else if (upd) begin
      bin_q[col_dly_q] <= bin_inc;
      // Strictly greater: on a tie the column that got there first keeps the peak.
      if (bin_inc > pk_cnt_q) begin
        pk_cnt_q <= bin_inc;
        pk_col_q <= col_dly_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_cnt_q     <= '0;
      peak_col_q     <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= (state_q == StReport);
      if (state_q == StReport) begin
        peak_cnt_q <= pk_cnt_q;
        peak_col_q <= pk_col_q;
      end
    end
  end

  assign peak_cnt     = peak_cnt_q;
  assign peak_col     = peak_col_q;
  assign result_valid = result_valid_q;

endmodule
